// File: rtl/result_bus_arbiter_pkg.sv
// Shared definitions for the result bus arbiter:
// data width default, mux select codes, FSM states.
package result_bus_arbiter_pkg;

  localparam int DATA_W_DEF = 9;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_C    = 2'b01;
  localparam logic [1:0] SEL_L    = 2'b10;
  localparam logic [1:0] SEL_IDLE = 2'b11;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Source that follows c in the A->C->L->A ring.
  function automatic logic [1:0] next_src(
    input logic [1:0] c
  );
    logic [1:0] n;
    unique case (1'b1)
      (c == SEL_A): n = SEL_C;
      (c == SEL_C): n = SEL_L;
      default:      n = SEL_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_pick3.sv
// Combinational 3-way round-robin picker.
// Ports: req[2:0] (A,C,L), ptr (first to scan) -> gnt one-hot, code.
module rr_pick3
  import result_bus_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] code
);

  logic [1:0] o0;
  logic [1:0] o1;
  logic [1:0] o2;

  // Scan order starting at the pointer; an
  // out-of-range pointer behaves like A.
  always_comb begin
    o0 = SEL_A;
    o1 = SEL_C;
    o2 = SEL_L;
    unique case (1'b1)
      (ptr == SEL_C): begin
        o0 = SEL_C;
        o1 = SEL_L;
        o2 = SEL_A;
      end
      (ptr == SEL_L): begin
        o0 = SEL_L;
        o1 = SEL_A;
        o2 = SEL_C;
      end
      default: ;
    endcase
  end

  always_comb begin
    gnt  = 3'b000;
    code = SEL_IDLE;
    if (req[o0]) begin
      gnt[o0] = 1'b1;
      code    = o0;
    end else if (req[o1]) begin
      gnt[o1] = 1'b1;
      code    = o1;
    end else if (req[o2]) begin
      gnt[o2] = 1'b1;
      code    = o2;
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Round-robin sequencer for the shared result mux
// (A=00, C=01, L=10, idle=11) with a registered
// valid/ready result stage toward writeback.
// Ports: clk, rst (sync, active-high); a/c/l_valid in,
// a/c/l_ready out; mux_sel out, mux_in in; out_valid,
// out_data, out_src out; out_ready in.
// ARB_GRANT_CNT_EN adds saturating per-source grant
// counters a_cnt, c_cnt, l_cnt (CNT_W bits).
// Timing: out_ready reaches mux_sel and the readys
// combinationally, only through can_load.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              c_valid,
  input  logic              l_valid,
  output logic              a_ready,
  output logic              c_ready,
  output logic              l_ready,
  output logic [1:0]        mux_sel,
  input  logic [DATA_W-1:0] mux_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  input  logic              out_ready
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  c_cnt,
  output logic [CNT_W-1:0]  l_cnt
`endif
);

  logic [0:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        src_q, src_d;

  logic       can_load;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] code;
  logic       grant;

  // Nothing is granted while in reset so the
  // readys read 0 throughout the reset pulse.
  always_comb begin
    can_load = (state_q == ST_EMPTY) | out_ready;
    req = 3'b000;
    if (can_load && !rst) begin
      req = {l_valid, c_valid, a_valid};
    end
  end

  rr_pick3 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .gnt  (gnt),
    .code (code)
  );

  always_comb begin
    grant   = |gnt;
    a_ready = gnt[0];
    c_ready = gnt[1];
    l_ready = gnt[2];
    mux_sel = code;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (grant) begin
      state_d = ST_FULL;
      data_d  = mux_in;
      src_d   = code;
      ptr_d   = next_src(code);
    end else if (can_load) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ptr_q   <= SEL_A;
      data_q  <= '0;
      src_q   <= SEL_IDLE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] c_cnt_q, c_cnt_d;
  logic [CNT_W-1:0] l_cnt_q, l_cnt_d;

  // Counters stick at all-ones.
  always_comb begin
    a_cnt_d = a_cnt_q;
    c_cnt_d = c_cnt_q;
    l_cnt_d = l_cnt_q;
    if (gnt[0] && !(&a_cnt_q)) a_cnt_d = a_cnt_q + 1'b1;
    if (gnt[1] && !(&c_cnt_q)) c_cnt_d = c_cnt_q + 1'b1;
    if (gnt[2] && !(&l_cnt_q)) l_cnt_d = l_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_cnt_q <= '0;
      c_cnt_q <= '0;
      l_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      c_cnt_q <= c_cnt_d;
      l_cnt_q <= l_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign c_cnt = c_cnt_q;
  assign l_cnt = l_cnt_q;
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: directed scenarios with
// literal expectations plus randomized traffic vs a model.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0;
  logic       c_valid = 1'b0;
  logic       l_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       a_ready, c_ready, l_ready;
  logic [1:0] mux_sel, out_src;
  logic [8:0] mux_in, out_data;
  logic       out_valid;
  logic [8:0] src_data [3];
`ifdef ARB_GRANT_CNT_EN
  logic [7:0] a_cnt, c_cnt, l_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Stand-in for the external shared mux.
  always_comb begin
    mux_in = 9'h000;
    case (mux_sel)
      2'b00: mux_in = src_data[0];
      2'b01: mux_in = src_data[1];
      2'b10: mux_in = src_data[2];
      default: mux_in = 9'h000;
    endcase
  end

  result_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .c_valid   (c_valid),
    .l_valid   (l_valid),
    .a_ready   (a_ready),
    .c_ready   (c_ready),
    .l_ready   (l_ready),
    .mux_sel   (mux_sel),
    .mux_in    (mux_in),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef ARB_GRANT_CNT_EN
    ,
    .a_cnt     (a_cnt),
    .c_cnt     (c_cnt),
    .l_cnt     (l_cnt)
`endif
  );

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  function automatic logic vld(input int s);
    return (s == 0) ? a_valid :
           (s == 1) ? c_valid : l_valid;
  endfunction

  // Reference model: pointer index, full flag, held result.
  int         m_ptr = 0;
  bit         m_full = 0;
  logic [8:0] m_data = 9'h000;
  int         m_src = 3;
  int         m_g;
  int         m_s;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_g = -1;
      if (!rst && (!m_full || out_ready)) begin
        for (int k = 0; k < 3; k++) begin
          m_s = (m_ptr + k) % 3;
          if (m_g < 0 && vld(m_s)) m_g = m_s;
        end
      end
      chk("m_a_ready", a_ready, m_g == 0);
      chk("m_c_ready", c_ready, m_g == 1);
      chk("m_l_ready", l_ready, m_g == 2);
      chk("m_mux_sel", mux_sel, (m_g < 0) ? 3 : m_g);
      chk("m_out_valid", out_valid, m_full);
      if (m_full) begin
        chk("m_out_data", out_data, m_data);
        chk("m_out_src", out_src, m_src);
      end
      @(posedge clk);
      if (rst) begin
        m_ptr  = 0;
        m_full = 0;
      end else if (m_g >= 0) begin
        m_full = 1;
        m_data = src_data[m_g];
        m_src  = m_g;
        m_ptr  = (m_g + 1) % 3;
      end else if (!m_full || out_ready) begin
        m_full = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_v(input logic a, input logic c,
                       input logic l);
    a_valid = a;
    c_valid = c;
    l_valid = l;
  endtask

  initial begin
    src_data[0] = 9'h011;
    src_data[1] = 9'h022;
    src_data[2] = 9'h033;
    rst = 1'b1;
    out_ready = 1'b1;
    set_v(1, 1, 1);
    // Reset with every source requesting.
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_c_ready", c_ready, 0);
    chk("rst_l_ready", l_ready, 0);
    chk("rst_mux_sel", mux_sel, 2'b11);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src", out_src, 2'b11);
    chk("rst_out_data", out_data, 9'h000);
    step();
    rst = 1'b0;

    // Single source L.
    set_v(0, 0, 1);
    src_data[2] = 9'h1A5;
    @(negedge clk);
    chk("single_l_ready", l_ready, 1);
    chk("single_sel", mux_sel, 2'b10);
    step();
    set_v(0, 0, 0);
    @(negedge clk);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 9'h1A5);
    chk("single_src", out_src, 2'b10);
    step();

    // Round robin with everyone requesting.
    src_data[2] = 9'h033;
    set_v(1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_sel", mux_sel, i % 3);
      if (i > 0) chk("rr_src", out_src, (i - 1) % 3);
      step();
    end

    // Backpressure while holding L's result.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_sel", mux_sel, 2'b11);
      chk("bp_ready", {a_ready, c_ready, l_ready}, 0);
      chk("bp_data", out_data, 9'h033);
      chk("bp_valid", out_valid, 1);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_reload_sel", mux_sel, 2'b00);
    chk("bp_reload_a", a_ready, 1);
    step();

    // Pointer now at C; only A and L request.
    set_v(1, 0, 1);
    @(negedge clk);
    chk("reload_src", out_src, 2'b00);
    chk("reload_data", out_data, 9'h011);
    chk("skip_sel0", mux_sel, 2'b10);
    step();
    @(negedge clk);
    chk("skip_sel1", mux_sel, 2'b00);
    step();
    @(negedge clk);
    chk("skip_sel2", mux_sel, 2'b10);
    step();

    // Reset while full and stalled.
    out_ready = 1'b0;
    set_v(0, 0, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", out_valid, 0);
`ifdef ARB_GRANT_CNT_EN
    chk("midrst_a_cnt", a_cnt, 0);
    chk("midrst_l_cnt", l_cnt, 0);
`endif
    step();
    set_v(1, 1, 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_ptr_a", mux_sel, 2'b00);
    step();

`ifdef ARB_GRANT_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_v(1, 0, 0);
    repeat (300) step();
    @(negedge clk);
    chk("cnt_a_sat", a_cnt, 8'hFF);
    chk("cnt_c_zero", c_cnt, 0);
    step();
`endif

    // Randomized traffic; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom % 150) == 0;
      set_v(($urandom % 3) != 0, ($urandom % 3) != 0,
            ($urandom % 3) != 0);
      out_ready = ($urandom % 4) != 0;
      src_data[0] = 9'($urandom);
      src_data[1] = 9'($urandom);
      src_data[2] = 9'($urandom);
      step();
    end

    rst = 1'b0;
    set_v(0, 0, 0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/result_bus_arbiter.md
Name: result_bus_arbiter

Overview:
Sequences the shared 9-bit result multiplexer among three producers: arithmetic (A), compare (C) and logic (L).
- Arbitrates their valid/ready requests round-robin.
- Drives the mux 2-bit select and captures the mux output into a registered result stage with a valid/ready handshake toward the writeback/display logic.
- Sits between the functional units and the result consumer; the existing mux remains a separate instance fed by this block's select.

Parameters:
DATA_W, 9, width of mux data path and registered result
CNT_W, 8, width of per-source grant counters (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
a_valid  in  1  arithmetic unit has a result on mux input 00
c_valid  in  1  compare unit has a result on mux input 01
l_valid  in  1  logic unit has a result on mux input 10
a_ready  out  1  arithmetic result accepted this cycle
c_ready  out  1  compare result accepted this cycle
l_ready  out  1  logic result accepted this cycle
mux_sel  out  2  select to shared mux: 00=A, 01=C, 10=L, 11=idle (mux outputs zero)
mux_in  in  DATA_W  output of shared mux
out_valid  out  1  registered result valid
out_data  out  DATA_W  registered result
out_src  out  2  encoding of source that produced out_data
out_ready  in  1  consumer accepts out_data

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=11, rr pointer=A, all *_ready=0, mux_sel=11, FSM=EMPTY. Optional counters are also cleared.
- can_load = (state==EMPTY) | out_ready.
- Grant, combinational:
  - If can_load, pick the first valid source scanning from the rr pointer in order A→C→L→A.
  - Assert only that source's ready and drive mux_sel to its code.
  - If no grant, mux_sel=11 and all readys are 0.
- Capture: on a granted cycle, out_data<=mux_in, out_src<=mux_sel, out_valid<=1 next edge. Latency is 1 cycle from grant to out_valid.
- Pointer: after a grant to source X, the pointer moves to the source after X (L wraps to A). It is unchanged with no grant.
- FSM states:
  - EMPTY: grant present → FULL; otherwise stay.
  - FULL: out_ready & grant → FULL (back-to-back reload, 1 result/cycle); out_ready & no grant → EMPTY with out_valid=0; !out_ready → hold out_data/out_src stable and grant nothing.
- Simultaneous requests: exactly one ready per cycle, never more.
- A requester holds valid until its ready. Dropping valid before ready is legal and simply removes it from arbitration.
- out_data is stable whenever out_valid=1 and out_ready=0.
- Reset mid-operation discards any held result. The pointer returns to A.
- No combinational path from out_ready to mux_sel other than through can_load; this path is documented for timing.

Optional Feature:
ARB_GRANT_CNT_EN
- Defined: three CNT_W-bit counters, a_cnt, c_cnt and l_cnt, exposed as extra outputs. Each increments on its source's grant, saturates at all-ones, and clears on rst.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package: DATA_W default, select codes SEL_A=2'b00, SEL_C=2'b01, SEL_L=2'b10, SEL_IDLE=2'b11, and FSM state encoding EMPTY/FULL.
- One sub-module, rr_pick3: combinational 3-way round-robin picker with 3-bit requests and a 2-bit pointer in, and a one-hot grant plus 2-bit code out.

Test Plan:
1. Reset: assert rst for 2 cycles with all valids high → all readys 0, mux_sel=11, out_valid=0, out_src=11.
2. Single source: l_valid=1 with mux_in=9'h1A5 on sel 10, out_ready=1 → l_ready=1 in the same cycle; next cycle out_valid=1, out_data=9'h1A5, out_src=10.
3. Round-robin: all three valid continuously, out_ready=1 → grants A,C,L,A,C,L on consecutive cycles; out_src follows one cycle later at 1 result/cycle.
4. Backpressure: out_ready=0 with a result held → no readys, mux_sel=11 and out_data constant for 5 cycles; raising out_ready reloads the next granted source on the same edge.
5. Pointer wrap and skip: only A and L valid, pointer at C → L granted first, then A, then L.
6. Reset mid-operation: rst while FULL with out_ready=0 → next cycle out_valid=0 and pointer=A. With ARB_GRANT_CNT_EN, counters read 0, and 300 A grants leave a_cnt saturated at 8'hFF.
